// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared 7-segment encodings, digit-enable codes and slot index
//             type for the three-digit display scanner.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Scan slot index: 0 = units, 1 = tens, 2 = hundreds.
    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_UNITS = 2'd0;
    localparam slot_t SLOT_TENS  = 2'd1;
    localparam slot_t SLOT_HUND  = 2'd2;

    // Segment patterns, bit order {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    // One-hot digit enables, active-high.
    localparam logic [2:0] DISP_UNITS = 3'b001;
    localparam logic [2:0] DISP_TENS  = 3'b010;
    localparam logic [2:0] DISP_HUND  = 3'b100;
    localparam logic [2:0] DISP_OFF   = 3'b000;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_seg7
//  Purpose  : Combinational BCD to 7-segment encoder; non-BCD codes (10-15)
//             produce a dash so a corrupted digit is visibly wrong.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Table lookup with the dash as the catch-all for invalid codes.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/seg_scan3.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan3
//  Purpose  : Three-digit multiplexed 7-segment scanner. Captures a coherent
//             snapshot of the digits once per frame, blanks the start of every
//             digit slot to prevent ghosting, and optionally suppresses
//             leading zeros. All outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan3
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 33334,  // clocks per digit slot
    parameter int BLANK_CYC = 1000,   // dark clocks at the start of each slot
    parameter int LZ_BLANK  = 1       // 1 = hide leading zeros
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] digit_units,
    input  logic [3:0] digit_tens,
    input  logic [3:0] digit_hund,
    output logic [6:0] segments,
    output logic [2:0] display,
    output logic       frame_start
);

    localparam int              c_cw       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(SCAN_DIV - 1);
    localparam logic [c_cw-1:0] c_blank    = c_cw'(BLANK_CYC);

    logic [c_cw-1:0] r_cnt;
    slot_t           r_slot;
    logic [3:0]      r_snap_u;
    logic [3:0]      r_snap_t;
    logic [3:0]      r_snap_h;

    logic            w_wrap;
    logic            w_frame;
    slot_t           w_slot_nxt;
    logic [3:0]      w_digit;
    logic [6:0]      w_seg_enc;
    logic            w_suppress;
    logic [2:0]      w_disp_nxt;
    logic [6:0]      w_seg_nxt;

    assign w_wrap  = (r_cnt == c_cnt_last);
    // Frame boundary: the snapshot is taken at the very first clock of slot 0.
    assign w_frame = (r_slot == SLOT_UNITS) && (r_cnt == '0);

    // Slot sequencing: units -> tens -> hundreds -> units at each slot wrap.
    always_comb begin
        w_slot_nxt = r_slot;
        if (w_wrap) begin
            case (r_slot)
                SLOT_UNITS: w_slot_nxt = SLOT_TENS;
                SLOT_TENS:  w_slot_nxt = SLOT_HUND;
                default:    w_slot_nxt = SLOT_UNITS;
            endcase
        end
    end

    // Select the snapshot digit belonging to the current slot.
    always_comb begin
        w_digit = r_snap_u;
        case (r_slot)
            SLOT_TENS: w_digit = r_snap_t;
            SLOT_HUND: w_digit = r_snap_h;
            default:   w_digit = r_snap_u;
        endcase
    end

    bcd_to_seg7 u_enc (
        .i_digit (w_digit),
        .o_seg   (w_seg_enc)
    );

    // Leading-zero suppression; only true zeros count, so invalid codes still
    // show their dash.
    always_comb begin
        w_suppress = 1'b0;
        if (LZ_BLANK != 0) begin
            case (r_slot)
                SLOT_HUND: w_suppress = (r_snap_h == 4'd0);
                SLOT_TENS: w_suppress = (r_snap_h == 4'd0) && (r_snap_t == 4'd0);
                default:   w_suppress = 1'b0;
            endcase
        end
    end

    // Next output values: dark during the blanking guard or when suppressed.
    always_comb begin
        w_disp_nxt = DISP_OFF;
        w_seg_nxt  = SEG_BLANK;
        if ((r_cnt >= c_blank) && !w_suppress) begin
            case (r_slot)
                SLOT_UNITS: begin w_disp_nxt = DISP_UNITS; w_seg_nxt = w_seg_enc; end
                SLOT_TENS:  begin w_disp_nxt = DISP_TENS;  w_seg_nxt = w_seg_enc; end
                SLOT_HUND:  begin w_disp_nxt = DISP_HUND;  w_seg_nxt = w_seg_enc; end
                default:    begin w_disp_nxt = DISP_OFF;   w_seg_nxt = SEG_BLANK; end
            endcase
        end
    end

    // Prescaler, slot state, snapshot and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_slot      <= SLOT_UNITS;
            r_snap_u    <= 4'd0;
            r_snap_t    <= 4'd0;
            r_snap_h    <= 4'd0;
            display     <= DISP_OFF;
            segments    <= SEG_BLANK;
            frame_start <= 1'b0;
        end else if (!en) begin
            // Parked: dark and rewound, but the last snapshot is kept.
            r_cnt       <= '0;
            r_slot      <= SLOT_UNITS;
            display     <= DISP_OFF;
            segments    <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            r_cnt       <= w_wrap ? '0 : r_cnt + 1'b1;
            r_slot      <= w_slot_nxt;
            frame_start <= w_frame;
            if (w_frame) begin
                r_snap_u <= digit_units;
                r_snap_t <= digit_tens;
                r_snap_h <= digit_hund;
            end
            display     <= w_disp_nxt;
            segments    <= w_seg_nxt;
        end
    end

endmodule : seg_scan3
`default_nettype wire

// File: tb/tb_seg_scan3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan3
//  Purpose  : Directed self-checking bench for seg_scan3 (SCAN_DIV=8,
//             BLANK_CYC=2); one instance with leading-zero suppression and one
//             without, both fed the same stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan3;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] digit_units;
    logic [3:0] digit_tens;
    logic [3:0] digit_hund;
    logic [6:0] segments,  segments0;
    logic [2:0] display,   display0;
    logic       frame_start, frame_start0;

    int total = 0;
    int bad   = 0;
    logic inv_on = 1'b0;

    seg_scan3 #(.SCAN_DIV(8), .BLANK_CYC(2), .LZ_BLANK(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .digit_units (digit_units),
        .digit_tens  (digit_tens),
        .digit_hund  (digit_hund),
        .segments    (segments),
        .display     (display),
        .frame_start (frame_start)
    );

    seg_scan3 #(.SCAN_DIV(8), .BLANK_CYC(2), .LZ_BLANK(0)) dut0 (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .digit_units (digit_units),
        .digit_tens  (digit_tens),
        .digit_hund  (digit_hund),
        .segments    (segments0),
        .display     (display0),
        .frame_start (frame_start0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Display invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (inv_on) begin
            chk("inv onehot", {6'd0, (display == 3'b000 || display == 3'b001 ||
                                      display == 3'b010 || display == 3'b100)}, 7'd1);
            chk("inv dark",   {6'd0, (display != 3'b000 || segments == 7'd0)}, 7'd1);
            chk("inv onehot0", {6'd0, (display0 == 3'b000 || display0 == 3'b001 ||
                                       display0 == 3'b010 || display0 == 3'b100)}, 7'd1);
            chk("inv dark0",  {6'd0, (display0 != 3'b000 || segments0 == 7'd0)}, 7'd1);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs n edges of a frame starting at edge 0 and checks every edge.
    // su/st/sh: expected segments per slot for the suppressing instance,
    // on_t/on_h: whether tens/hundreds light at all, st0/sh0: non-suppressing.
    task automatic run_frame(input string tag, input int n,
                             input logic [6:0] su, input logic [6:0] st, input logic [6:0] sh,
                             input logic on_t, input logic on_h,
                             input logic [6:0] st0, input logic [6:0] sh0,
                             input int chg_edge, input logic [3:0] chg_val);
        for (int e = 0; e < n; e++) begin
            int s, c;
            logic [2:0] ed, ed0;
            logic [6:0] es, es0;
            if (e == chg_edge) digit_units = chg_val;
            step;
            s = e / 8;
            c = e % 8;
            ed = 3'b000; es = 7'd0; ed0 = 3'b000; es0 = 7'd0;
            if (c >= 2) begin
                if (s == 0) begin
                    ed = 3'b001; es = su; ed0 = 3'b001; es0 = su;
                end else if (s == 1) begin
                    if (on_t) begin ed = 3'b010; es = st; end
                    ed0 = 3'b010; es0 = st0;
                end else begin
                    if (on_h) begin ed = 3'b100; es = sh; end
                    ed0 = 3'b100; es0 = sh0;
                end
            end
            chk($sformatf("%s e%0d display", tag, e), {4'd0, display}, {4'd0, ed});
            chk($sformatf("%s e%0d segments", tag, e), segments, es);
            chk($sformatf("%s e%0d frame_start", tag, e), {6'd0, frame_start}, {6'd0, (e == 0)});
            chk($sformatf("%s e%0d display0", tag, e), {4'd0, display0}, {4'd0, ed0});
            chk($sformatf("%s e%0d segments0", tag, e), segments0, es0);
        end
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, " display"},     {4'd0, display},  7'd0);
        chk({tag, " segments"},    segments,         7'd0);
        chk({tag, " frame_start"}, {6'd0, frame_start}, 7'd0);
        chk({tag, " display0"},    {4'd0, display0}, 7'd0);
        chk({tag, " segments0"},   segments0,        7'd0);
    endtask

    initial begin
        reset = 1'b1; en = 1'b1;
        digit_hund = 4'd1; digit_tens = 4'd2; digit_units = 4'd3;
        step; step;
        chk_dark("reset");
        inv_on = 1'b1;
        reset = 1'b0;

        // 123: basic scan order and timing.
        run_frame("f0_123", 24, 7'b1111001, 7'b1101101, 7'b0110000, 1'b1, 1'b1,
                  7'b1101101, 7'b0110000, -1, 4'd0);
        // Units changes to 9 mid-frame: this frame keeps 3.
        run_frame("f1_snap", 24, 7'b1111001, 7'b1101101, 7'b0110000, 1'b1, 1'b1,
                  7'b1101101, 7'b0110000, 4, 4'd9);
        run_frame("f2_129", 24, 7'b1111011, 7'b1101101, 7'b0110000, 1'b1, 1'b1,
                  7'b1101101, 7'b0110000, -1, 4'd0);

        // 007: tens and hundreds suppressed.
        digit_hund = 4'd0; digit_tens = 4'd0; digit_units = 4'd7;
        run_frame("f3_007", 24, 7'b1110000, 7'd0, 7'd0, 1'b0, 1'b0,
                  7'b1111110, 7'b1111110, -1, 4'd0);

        // 050: only hundreds suppressed.
        digit_hund = 4'd0; digit_tens = 4'd5; digit_units = 4'd0;
        run_frame("f4_050", 24, 7'b1111110, 7'b1011011, 7'd0, 1'b1, 1'b0,
                  7'b1011011, 7'b1111110, -1, 4'd0);

        // Units 12 shows a dash; leading zeros still hidden.
        digit_hund = 4'd0; digit_tens = 4'd0; digit_units = 4'd12;
        run_frame("f5_00C", 24, 7'b0000001, 7'd0, 7'd0, 1'b0, 1'b0,
                  7'b1111110, 7'b1111110, -1, 4'd0);

        // Hundreds 11 is not a zero: dash shows and tens 0 stays lit.
        digit_hund = 4'd11; digit_tens = 4'd0; digit_units = 4'd4;
        run_frame("f6_B04", 24, 7'b0110011, 7'b1111110, 7'b0000001, 1'b1, 1'b1,
                  7'b1111110, 7'b0000001, -1, 4'd0);

        // Reset at edge 12 of a frame.
        digit_hund = 4'd1; digit_tens = 4'd2; digit_units = 4'd3;
        run_frame("f7_pre", 12, 7'b1111001, 7'b1101101, 7'b0110000, 1'b1, 1'b1,
                  7'b1101101, 7'b0110000, -1, 4'd0);
        reset = 1'b1;
        step;
        chk_dark("reset_mid");
        reset = 1'b0;
        run_frame("f8_post_rst", 24, 7'b1111001, 7'b1101101, 7'b0110000, 1'b1, 1'b1,
                  7'b1101101, 7'b0110000, -1, 4'd0);

        // Enable dropped at edge 12, then restored.
        run_frame("f9_pre", 12, 7'b1111001, 7'b1101101, 7'b0110000, 1'b1, 1'b1,
                  7'b1101101, 7'b0110000, -1, 4'd0);
        en = 1'b0;
        step;
        chk_dark("en_off1");
        step;
        chk_dark("en_off2");
        en = 1'b1;
        run_frame("f10_post_en", 24, 7'b1111001, 7'b1101101, 7'b0110000, 1'b1, 1'b1,
                  7'b1101101, 7'b0110000, -1, 4'd0);

        inv_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seg_scan3
`default_nettype wire
